// File: rtl/srreg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srreg_ctrl_pkg
// Description : Shared opcode, status and FSM state encodings for the
//               set/reset register bank controller.
// Revision    : 1.0  initial release
// ============================================================================
package srreg_ctrl_pkg;

    localparam int c_OP_W   = 2;
    localparam int c_STAT_W = 2;

    // Command opcodes as presented on REQ_OP
    typedef enum logic [c_OP_W-1:0] {
        OP_CLR  = 2'b00,
        OP_SET  = 2'b01,
        OP_LOAD = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    // Response status codes as presented on RSP_STATUS
    typedef enum logic [c_STAT_W-1:0] {
        STAT_OK       = 2'b00,
        STAT_MISMATCH = 2'b01,
        STAT_ILLEGAL  = 2'b10
    } status_e;

    // Controller sequencing states
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_APPLY  = 3'd2,
        S_VERIFY = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/srreg_bank_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches from the pointer upward for the
//               first active request; the pointer moves past the winner only
//               when the caller strobes i_advance.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_advance,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_j;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan requesters starting at the pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_j >= (IDX_W+1)'(NREQ)) begin
                w_j = w_j - (IDX_W+1)'(NREQ);
            end
            if (!w_found && i_req[w_j[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_j[IDX_W-1:0];
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_grant = w_found ? (NREQ'(1) << w_idx) : '0;

    // Pointer moves to the slot after the accepted winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == IDX_W'(NREQ-1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/srreg_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : srreg_bank_ctrl
// Description : Arbitrates masked CLR/SET/LOAD commands onto a bank of
//               set/reset flops, pulses the bank controls for one cycle,
//               verifies the read-back and returns a status response.
// Revision    : 1.0  initial release
// ============================================================================
module srreg_bank_ctrl
    import srreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [2*NREQ-1:0]       i_req_op,
    input  logic [NREQ*WIDTH-1:0]   i_req_mask,
    input  logic [NREQ*WIDTH-1:0]   i_req_data,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [$clog2(NREQ)-1:0] o_rsp_id,
    output logic [1:0]              o_rsp_status,
    output logic [WIDTH-1:0]        o_rsp_q,
    output logic [WIDTH-1:0]        o_bank_r_n,
    output logic [WIDTH-1:0]        o_bank_s_n,
    output logic [WIDTH-1:0]        o_bank_d,
    input  logic [WIDTH-1:0]        i_bank_q,
    output logic [CNT_W-1:0]        o_err_cnt
);

    localparam int ID_W = $clog2(NREQ);

    state_e           r_state, w_state_nxt;
    op_e              r_op;
    logic [WIDTH-1:0] r_mask, r_data, r_qp;
    logic [ID_W-1:0]  r_id;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    status_e          r_rsp_status;
    logic [WIDTH-1:0] r_rsp_q;
    logic [CNT_W-1:0] r_err_cnt;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_advance;
    op_e              w_sel_op;
    logic [WIDTH-1:0] w_val, w_exp;

    assign w_advance = (r_state == S_IDLE) && (|i_req_valid);
    assign w_sel_op  = op_e'(i_req_op[w_gnt_idx*2 +: 2]);

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req_valid),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_idx     (w_gnt_idx)
    );

    assign o_req_ready = (r_state == S_IDLE) ? w_grant : '0;

    // Value the masked bits should take after the command
    always_comb begin
        w_val = '0;
        case (r_op)
            OP_SET:  w_val = '1;
            OP_LOAD: w_val = r_data;
            default: w_val = '0;
        endcase
        w_exp = (r_qp & ~r_mask) | (w_val & r_mask);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bank controls; every bank bit holds unless commanded
    always_comb begin
        w_state_nxt = r_state;
        o_bank_r_n  = '1;
        o_bank_s_n  = '1;
        o_bank_d    = i_bank_q;
        case (r_state)
            S_INIT: begin
                o_bank_r_n  = '0;
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_advance) begin
                    w_state_nxt = (w_sel_op == OP_ILL) ? S_RESP : S_APPLY;
                end
            end
            S_APPLY: begin
                case (r_op)
                    OP_CLR:  o_bank_r_n = ~r_mask;
                    OP_SET:  o_bank_s_n = ~r_mask;
                    OP_LOAD: o_bank_d   = (i_bank_q & ~r_mask) | (r_data & r_mask);
                    default: o_bank_d   = i_bank_q;
                endcase
                w_state_nxt = S_VERIFY;
            end
            S_VERIFY: w_state_nxt = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Capture the granted command and the pre-update bank snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= OP_CLR;
            r_mask <= '0;
            r_data <= '0;
            r_qp   <= '0;
            r_id   <= '0;
        end else if (w_advance) begin
            r_op   <= w_sel_op;
            r_mask <= i_req_mask[w_gnt_idx*WIDTH +: WIDTH];
            r_data <= i_req_data[w_gnt_idx*WIDTH +: WIDTH];
            r_qp   <= i_bank_q;
            r_id   <= w_gnt_idx;
        end
    end

    // Response fields and saturating mismatch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_status <= STAT_OK;
            r_rsp_q      <= '0;
            r_err_cnt    <= '0;
        end else if (w_advance && (w_sel_op == OP_ILL)) begin
            // Illegal ops skip the bank entirely; report the untouched bank
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_gnt_idx;
            r_rsp_status <= STAT_ILLEGAL;
            r_rsp_q      <= i_bank_q;
        end else if (r_state == S_VERIFY) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_status <= (i_bank_q == w_exp) ? STAT_OK : STAT_MISMATCH;
            r_rsp_q      <= i_bank_q;
        end else if ((r_state == S_RESP) && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if ((r_rsp_status == STAT_MISMATCH) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_status = r_rsp_status;
    assign o_rsp_q      = r_rsp_q;
    assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/srreg_bank_ctrl.md
# srreg_bank_ctrl

Sequencing and arbitration controller for a bank of WIDTH set/reset flip-flops (active-low R dominates active-low S, otherwise capture D on CLK). Accepts masked CLEAR/SET/LOAD commands from NREQ requesters, grants them round-robin, and drives the bank's R, S and D lines for exactly one cycle. It reads back Q to verify the update and returns a status response. It also clears the whole bank on reset.

## Interface
- WIDTH, 8: bank width in bits.
- NREQ, 2: number of requesters (≥2).
- CNT_W, 8: width of the mismatch counter.

- CLK  in  1  clock; the controller and the bank are both clocked on the posedge.
- RST  in  1  reset; one clock, RST synchronous and active-high.
- REQ_VALID  in  NREQ  per-requester command valid.
- REQ_READY  out  NREQ  per-requester accept; one-hot or zero.
- REQ_OP  in  NREQ×2  opcode per requester: 00 CLR, 01 SET, 10 LOAD, 11 illegal.
- REQ_MASK  in  NREQ×WIDTH  bits affected by the command.
- REQ_DATA  in  NREQ×WIDTH  LOAD data; ignored for other ops.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accept.
- RSP_ID  out  $clog2(NREQ)  index of the served requester.
- RSP_STATUS  out  2  00 OK, 01 MISMATCH, 10 ILLEGAL.
- RSP_Q  out  WIDTH  bank value sampled in VERIFY.
- BANK_R_N  out  WIDTH  per-bit reset to the bank, active-low.
- BANK_S_N  out  WIDTH  per-bit set to the bank, active-low.
- BANK_D  out  WIDTH  per-bit data to the bank.
- BANK_Q  in  WIDTH  bank outputs.
- ERR_CNT  out  CNT_W  saturating count of MISMATCH responses.

## Operation
- States: INIT, IDLE, APPLY, VERIFY, RESP.
- Hold rule: outside APPLY, BANK_R_N and BANK_S_N are all-ones and BANK_D = BANK_Q. Unmasked bits in APPLY follow the same rule.
  - BANK_D is combinational from BANK_Q. No bank bit may change except by command or INIT.
- INIT
  - Entered whenever RST is sampled high.
  - Drives BANK_R_N = all-zeros.
  - Moves to IDLE on the first cycle with RST low.
- IDLE
  - The arbiter grants the highest-priority valid requester. REQ_READY of that requester is high for one cycle.
  - The command, ID and BANK_Q snapshot (QP) are latched, then go to APPLY. An illegal op goes directly to RESP with status ILLEGAL and no bank activity.
- APPLY (exactly one cycle), for masked bits:
  - CLR: BANK_R_N = 0.
  - SET: BANK_S_N = 0.
  - LOAD: BANK_D = DATA.
  - Expected value EXP = (QP & ~MASK) | (V & MASK), where V = 0 for CLR, 1 for SET, DATA for LOAD.
- VERIFY: compare BANK_Q with EXP; latch RSP_Q and status (OK or MISMATCH); go to RESP.
- RESP
  - Hold RSP_VALID and all RSP_* fields stable until RSP_READY is high.
  - On that handshake cycle, move to IDLE and increment ERR_CNT if status was MISMATCH (saturate at all-ones).
- Round-robin
  - The pointer advances to grant_index+1 (mod NREQ) only on an accepted request.
  - After reset the pointer is 0. After reset requester 0 has priority.
- Reset mid-operation: on RST the state goes to INIT and the in-flight command is dropped with no response. RSP_VALID goes low, ERR_CNT goes to 0, and the pointer goes to 0.
- Reset values of registered outputs: RSP_VALID 0, RSP_ID 0, RSP_STATUS 00, RSP_Q 0, ERR_CNT 0.
- REQ_READY is 0 whenever the state is not IDLE.

## Timing
- Cycle t: handshake in IDLE.
- t+1: APPLY drives the controls; the bank updates at the edge ending t+1.
- t+2: VERIFY.
- t+3: RSP_VALID is high at the earliest.
- Throughput: at most one command per 4 cycles with RSP_READY tied high.
- Illegal op: RSP_VALID is high at t+1.
- Simultaneous REQ_VALID: one grant per cycle, chosen by the round-robin pointer. Losers hold their valid; they are never dropped.
- REQ_* must be stable while REQ_VALID is high and REQ_READY is low.

## Structure
- Shared package srreg_ctrl_pkg holds:
  - op_e (CLR/SET/LOAD/ILL);
  - status_e (OK/MISMATCH/ILLEGAL);
  - state_e;
  - the opcode and status encodings above.
- Sub-module rr_arbiter (parameter NREQ): inputs are the request vector and an advance strobe; outputs are the one-hot grant and the index.
- The FSM, the datapath (EXP, QP) and the counter live in srreg_bank_ctrl.

## Test plan
- Reset: hold RST 3 cycles with BANK_Q = 8'hFF. Required: BANK_R_N = 8'h00 during INIT, then all-ones in IDLE, bank reads 8'h00, ERR_CNT = 0.
- LOAD: requester 0 sends LOAD, MASK = 8'h0F, DATA = 8'hA5, bank 8'h30. Required: RSP at t+3 with STATUS OK, RSP_Q = 8'h35; bits 7:4 never toggle.
- Contention: both requesters valid back-to-back with SET, MASK = 8'h01 and 8'h80. Required: grants in order 0, 1, 0, 1; RSP_ID matches; bank ends 8'h81.
- Fault: a bench-forced stuck-at-0 on bit 2 with SET, MASK = 8'h04. Required: STATUS MISMATCH, ERR_CNT = 1; saturates at 255 after 300 repeats.
- Illegal and backpressure: OP = 11 gives STATUS ILLEGAL at t+1 with no bank activity. With RSP_READY low for 5 cycles, the fields stay stable and REQ_READY stays 0.
- Reset mid-operation: assert RST during APPLY. Required: no response, state INIT, bank cleared, ERR_CNT = 0.
